// File: rtl/crs_bwr_port_if.sv
// Local command, buffered-write and arbiter-slot signals of crs_bwr_port.
// The slave view belongs to the port itself; the master view belongs to its surroundings.
interface crs_bwr_port_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_rd;
    logic [11:0] cmd_adr;
    logic [15:0] cmd_wr_data;
    logic        cmd_done;
    logic [15:0] cmd_rd_data;

    logic        push;
    logic [11:0] push_adr;
    logic [15:0] push_data;
    logic        fifo_full;
    logic        fifo_ovf;
    logic        flush;

    logic        wr_req;
    logic        rd_req;
    logic        bwr_req;
    logic        ack;
    logic [11:0] adr;
    logic [15:0] wr_data;
    logic [15:0] rd_data;
    logic        buf_rd;
    logic        buf_empty;
    logic [31:0] buf_wr_data;

    modport slave (
        input  cmd_valid, cmd_rd, cmd_adr, cmd_wr_data,
        output cmd_ready, cmd_done, cmd_rd_data,
        input  push, push_adr, push_data, flush,
        output fifo_full, fifo_ovf,
        input  ack, rd_data, buf_rd,
        output wr_req, rd_req, bwr_req, adr, wr_data, buf_empty, buf_wr_data
    );

    modport master (
        output cmd_valid, cmd_rd, cmd_adr, cmd_wr_data,
        input  cmd_ready, cmd_done, cmd_rd_data,
        output push, push_adr, push_data, flush,
        input  fifo_full, fifo_ovf,
        output ack, rd_data, buf_rd,
        input  wr_req, rd_req, bwr_req, adr, wr_data, buf_empty, buf_wr_data
    );
endinterface

// File: rtl/crs_bwr_port.sv
// Arbiter slot adapter: single register accesses plus a buffered-write FIFO that is
// handed to the arbiter as a burst-write transaction on threshold, flush or idle timeout.
module crs_bwr_port #(
    parameter int DEPTH_LOG2   = 4,
    parameter int FLUSH_THRESH = 8,
    parameter int TIMEOUT      = 1000
) (
    input  logic           clk,
    input  logic           rst,
    crs_bwr_port_if.slave  bus
);
    localparam int              DEPTH    = 1 << DEPTH_LOG2;
    localparam int              CNT_W    = DEPTH_LOG2 + 1;
    localparam logic [15:0]     TMO_LAST = 16'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CMD_REQ,
        S_BWR_REQ,
        S_WAIT_ACK_LOW
    } state_t;

    state_t                state_q, state_d;
    logic                  wr_req_q, wr_req_d;
    logic                  rd_req_q, rd_req_d;
    logic                  bwr_req_q, bwr_req_d;
    logic                  cmd_done_q, cmd_done_d;
    logic                  is_rd_q, is_rd_d;
    logic [11:0]           adr_q, adr_d;
    logic [15:0]           wr_data_q, wr_data_d;
    logic [15:0]           cmd_rd_data_q, cmd_rd_data_d;

    logic [27:0]           mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [31:0]           buf_wr_data_q, buf_wr_data_d;
    logic                  fifo_ovf_q, fifo_ovf_d;
    logic                  flush_pend_q, flush_pend_d;
    logic [15:0]           tmo_q, tmo_d;

    logic fifo_empty, fifo_full, push_ok, pop_ok;
    logic tmo_expired, bwr_due, enter_bwr, leave_bwr;

    assign fifo_empty  = (count_q == '0);
    assign fifo_full   = (count_q == CNT_W'(DEPTH));
    assign push_ok     = bus.push && !fifo_full;
    assign pop_ok      = bus.buf_rd && !fifo_empty;
    assign tmo_expired = (TIMEOUT != 0) && (tmo_q == TMO_LAST);
    assign bwr_due     = (count_q >= CNT_W'(FLUSH_THRESH))
                       || (flush_pend_q && !fifo_empty)
                       || tmo_expired;
    assign enter_bwr   = (state_q != S_BWR_REQ) && (state_d == S_BWR_REQ);
    assign leave_bwr   = (state_q == S_BWR_REQ) && (state_d != S_BWR_REQ);

    always_comb begin
        // NOTE: every _d starts from its _q value so no branch can infer a latch.
        state_d       = state_q;
        wr_req_d      = wr_req_q;
        rd_req_d      = rd_req_q;
        bwr_req_d     = bwr_req_q;
        is_rd_d       = is_rd_q;
        adr_d         = adr_q;
        wr_data_d     = wr_data_q;
        cmd_rd_data_d = cmd_rd_data_q;
        cmd_done_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                // A pending single command always wins over a due burst.
                if (bus.cmd_valid) begin
                    adr_d     = bus.cmd_adr;
                    wr_data_d = bus.cmd_wr_data;
                    is_rd_d   = bus.cmd_rd;
                    wr_req_d  = !bus.cmd_rd;
                    rd_req_d  = bus.cmd_rd;
                    state_d   = S_CMD_REQ;
                end else if (bwr_due && !bus.ack) begin
                    bwr_req_d = 1'b1;
                    state_d   = S_BWR_REQ;
                end
            end
            S_CMD_REQ: begin
                if (bus.ack) begin
                    wr_req_d   = 1'b0;
                    rd_req_d   = 1'b0;
                    cmd_done_d = 1'b1;
                    if (is_rd_q) cmd_rd_data_d = bus.rd_data;
                    state_d    = S_WAIT_ACK_LOW;
                end
            end
            S_BWR_REQ: begin
                if (bus.ack) begin
                    bwr_req_d = 1'b0;
                    state_d   = S_WAIT_ACK_LOW;
                end
            end
            S_WAIT_ACK_LOW: begin
                if (!bus.ack) state_d = S_IDLE;
            end
            default: begin
                wr_req_d  = 1'b0;
                rd_req_d  = 1'b0;
                bwr_req_d = 1'b0;
                state_d   = S_IDLE;
            end
        endcase
    end

    always_comb begin
        wr_ptr_d      = wr_ptr_q + DEPTH_LOG2'(push_ok);
        rd_ptr_d      = rd_ptr_q + DEPTH_LOG2'(pop_ok);
        count_d       = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
        buf_wr_data_d = pop_ok ? {4'b0000, mem[rd_ptr_q]} : buf_wr_data_q;
        fifo_ovf_d    = fifo_ovf_q || (bus.push && fifo_full);

        flush_pend_d = flush_pend_q || bus.flush;
        if (enter_bwr || fifo_empty) flush_pend_d = 1'b0;

        // The idle timer saturates at its last value so a command cannot swallow the expiry.
        tmo_d = tmo_q;
        if (bus.push || fifo_empty || leave_bwr)
            tmo_d = '0;
        else if (state_q == S_IDLE && tmo_q != TMO_LAST)
            tmo_d = tmo_q + 16'd1;
    end

    // NOTE: FIFO storage has no reset; only pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_q] <= {bus.push_adr, bus.push_data};
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            wr_req_q      <= 1'b0;
            rd_req_q      <= 1'b0;
            bwr_req_q     <= 1'b0;
            cmd_done_q    <= 1'b0;
            is_rd_q       <= 1'b0;
            adr_q         <= '0;
            wr_data_q     <= '0;
            cmd_rd_data_q <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            buf_wr_data_q <= '0;
            fifo_ovf_q    <= 1'b0;
            flush_pend_q  <= 1'b0;
            tmo_q         <= '0;
        end else begin
            state_q       <= state_d;
            wr_req_q      <= wr_req_d;
            rd_req_q      <= rd_req_d;
            bwr_req_q     <= bwr_req_d;
            cmd_done_q    <= cmd_done_d;
            is_rd_q       <= is_rd_d;
            adr_q         <= adr_d;
            wr_data_q     <= wr_data_d;
            cmd_rd_data_q <= cmd_rd_data_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            buf_wr_data_q <= buf_wr_data_d;
            fifo_ovf_q    <= fifo_ovf_d;
            flush_pend_q  <= flush_pend_d;
            tmo_q         <= tmo_d;
        end
    end

    assign bus.cmd_ready   = (state_q == S_IDLE);
    assign bus.cmd_done    = cmd_done_q;
    assign bus.cmd_rd_data = cmd_rd_data_q;
    assign bus.wr_req      = wr_req_q;
    assign bus.rd_req      = rd_req_q;
    assign bus.bwr_req     = bwr_req_q;
    assign bus.adr         = adr_q;
    assign bus.wr_data     = wr_data_q;
    assign bus.fifo_full   = fifo_full;
    assign bus.fifo_ovf    = fifo_ovf_q;
    assign bus.buf_empty   = fifo_empty;
    assign bus.buf_wr_data = buf_wr_data_q;
endmodule
